// File: rtl/seq_pattern_tx_if.sv
// seq_pattern_tx_if: control/data bundle between a pattern source (master)
// and the serial transmitter (slave).
interface seq_pattern_tx_if #(
  parameter int NBITS_PAT = 8,
  parameter int LEN_W     = 4,
  parameter int NBITS_REP = 4
);
  logic                 start;
  logic                 abort;
  logic [NBITS_PAT-1:0] pattern;
  logic [LEN_W-1:0]     length;
  logic [NBITS_REP-1:0] repeat_cnt;
  logic                 out_bit;
  logic                 out_valid;
  logic                 busy;
  logic                 done;

  modport master (
    output start, abort, pattern, length, repeat_cnt,
    input  out_bit, out_valid, busy, done
  );

  modport slave (
    input  start, abort, pattern, length, repeat_cnt,
    output out_bit, out_valid, busy, done
  );
endinterface

// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: serial bit-pattern transmitter feeding the sequence
// detector. Captures pattern/length/repeat on start, shifts one bit per
// clk_2 cycle, one idle gap cycle between passes, done pulse at the end.
// SEG shows the bits remaining in the current pass.
// Build option: SEQ_TX_MSB_FIRST_EN sends pattern[eff_len-1] first;
// default build sends pattern[0] first.
module seq_pattern_tx #(
  parameter int NBITS_PAT = 8,
  parameter int LEN_W     = 4,
  parameter int NBITS_REP = 4
) (
  input  logic           clk_2,
  input  logic           reset,
  seq_pattern_tx_if.slave bus,
  output logic [7:0]     SEG
);
  localparam int REM_W = (LEN_W > 4) ? LEN_W : 4;

  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

  state_t               state, state_nxt;
  logic [NBITS_PAT-1:0] sreg, sreg_nxt;
  logic [NBITS_PAT-1:0] pat_q, pat_nxt;
  logic [LEN_W-1:0]     len_q, len_nxt;
  logic [NBITS_REP-1:0] reps_q, reps_nxt;
  logic [REM_W-1:0]     rem, rem_nxt;
  logic                 out_bit_q, out_bit_nxt;
  logic                 out_valid_q, out_valid_nxt;
  logic                 done_q, done_nxt;
  logic [7:0]           seg_nxt;

  logic [LEN_W-1:0]     in_len_eff;
  logic [NBITS_PAT-1:0] ld_pat, ld_rest;
  logic [LEN_W-1:0]     ld_len;
  logic                 ld_first;
  logic                 sh_bit;
  logic [NBITS_PAT-1:0] sh_rest;

  function automatic logic [7:0] seg_code(input logic [3:0] v);
    case (v)
      4'h0: seg_code = 8'h3F;
      4'h1: seg_code = 8'h06;
      4'h2: seg_code = 8'h5B;
      4'h3: seg_code = 8'h4F;
      4'h4: seg_code = 8'h66;
      4'h5: seg_code = 8'h6D;
      4'h6: seg_code = 8'h7D;
      4'h7: seg_code = 8'h07;
      4'h8: seg_code = 8'h7F;
      4'h9: seg_code = 8'h6F;
      4'hA: seg_code = 8'h77;
      4'hB: seg_code = 8'h7C;
      4'hC: seg_code = 8'h39;
      4'hD: seg_code = 8'h5E;
      4'hE: seg_code = 8'h79;
      default: seg_code = 8'h71;
    endcase
  endfunction

  // Pass-load source: live inputs when starting from IDLE, captured copy on GAP;
  // first bit and remaining shift contents for both bit orders.
  always_comb begin
    in_len_eff = (bus.length == '0 || bus.length > LEN_W'(NBITS_PAT))
                 ? LEN_W'(NBITS_PAT) : bus.length;
    ld_pat = (state == IDLE) ? bus.pattern : pat_q;
    ld_len = (state == IDLE) ? in_len_eff  : len_q;
`ifdef SEQ_TX_MSB_FIRST_EN
    // left-align the active field so the shift always leaves from the top bit
    ld_rest  = ld_pat << (NBITS_PAT - int'(ld_len));
    ld_first = ld_rest[NBITS_PAT-1];
    ld_rest  = ld_rest << 1;
    sh_bit   = sreg[NBITS_PAT-1];
    sh_rest  = sreg << 1;
`else
    ld_first = ld_pat[0];
    ld_rest  = ld_pat >> 1;
    sh_bit   = sreg[0];
    sh_rest  = sreg >> 1;
`endif
  end

  // Next-state and registered-output logic; abort outranks end-of-pass handling.
  always_comb begin
    state_nxt     = state;
    sreg_nxt      = sreg;
    pat_nxt       = pat_q;
    len_nxt       = len_q;
    reps_nxt      = reps_q;
    rem_nxt       = rem;
    out_bit_nxt   = out_bit_q;
    out_valid_nxt = out_valid_q;
    done_nxt      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          pat_nxt       = bus.pattern;
          len_nxt       = in_len_eff;
          reps_nxt      = bus.repeat_cnt;
          state_nxt     = SEND;
          sreg_nxt      = ld_rest;
          out_bit_nxt   = ld_first;
          out_valid_nxt = 1'b1;
          rem_nxt       = REM_W'(ld_len) - REM_W'(1);
        end
      end
      SEND: begin
        if (bus.abort) begin
          state_nxt     = IDLE;
          out_valid_nxt = 1'b0;
          out_bit_nxt   = 1'b0;
          rem_nxt       = '0;
        end else if (rem != '0) begin
          sreg_nxt    = sh_rest;
          out_bit_nxt = sh_bit;
          rem_nxt     = rem - REM_W'(1);
        end else if (reps_q != '0) begin
          state_nxt     = GAP;
          out_valid_nxt = 1'b0;
          out_bit_nxt   = 1'b0;
          reps_nxt      = reps_q - NBITS_REP'(1);
        end else begin
          state_nxt     = DONE;
          out_valid_nxt = 1'b0;
          out_bit_nxt   = 1'b0;
          done_nxt      = 1'b1;
        end
      end
      GAP: begin
        if (bus.abort) begin
          state_nxt     = IDLE;
          out_valid_nxt = 1'b0;
          out_bit_nxt   = 1'b0;
          rem_nxt       = '0;
        end else begin
          state_nxt     = SEND;
          sreg_nxt      = ld_rest;
          out_bit_nxt   = ld_first;
          out_valid_nxt = 1'b1;
          rem_nxt       = REM_W'(ld_len) - REM_W'(1);
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    seg_nxt = seg_code(rem_nxt[3:0]);
  end

  // State and output registers, asynchronously cleared.
  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      sreg        <= '0;
      pat_q       <= '0;
      len_q       <= '0;
      reps_q      <= '0;
      rem         <= '0;
      out_bit_q   <= 1'b0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      SEG         <= 8'h3F;
    end else begin
      state       <= state_nxt;
      sreg        <= sreg_nxt;
      pat_q       <= pat_nxt;
      len_q       <= len_nxt;
      reps_q      <= reps_nxt;
      rem         <= rem_nxt;
      out_bit_q   <= out_bit_nxt;
      out_valid_q <= out_valid_nxt;
      done_q      <= done_nxt;
      SEG         <= seg_nxt;
    end
  end

  assign bus.out_bit   = out_bit_q;
  assign bus.out_valid = out_valid_q;
  assign bus.done      = done_q;
  assign bus.busy      = (state != IDLE);
endmodule

// File: doc/seq_pattern_tx.md
Name: seq_pattern_tx

Overview:
- Serial bit-pattern transmitter: the generating end of the consecutive-ones sequence detector. It produces the in_bit stream that the detector consumes.
- Loads a pattern from switches on start, then shifts it out one bit per clk_2 cycle.
- Supports a programmable length and repeat count, with a one-cycle gap between passes.
- Drives a 7-segment digit showing the bits remaining in the current pass, and sits beside the detector on the board top level.

Parameters:
- NBITS_PAT, 8, maximum pattern width in bits.
- LEN_W, 4, width of the length input; must satisfy 2^LEN_W > NBITS_PAT.
- NBITS_REP, 4, width of the repeat-count input.

Ports:
- clk_2  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  level; sampled each rising edge; accepted only in IDLE.
- abort  input  1  level; cancels a transfer in progress.
- pattern  input  NBITS_PAT  bits to send, captured at start.
- length  input  LEN_W  bits per pass, captured at start.
- repeat_cnt  input  NBITS_REP  extra passes after the first, captured at start.
- out_bit  output  1  serial data; valid when out_valid=1.
- out_valid  output  1  high on every cycle that carries a pattern bit.
- busy  output  1  high when state is not IDLE.
- done  output  1  one-cycle pulse after the final pass completes.
- SEG  output  8  7-segment code of rem[3:0]; bit7 is always 0.

Behaviour:
- Clock and reset: reset is asynchronous, active-high; clock is clk_2.
- State machine: IDLE, SEND, GAP, DONE. All outputs are registered; busy is decoded from the state register.
- Reset values: state=IDLE, out_bit=0, out_valid=0, done=0, rem=0, shift register=0, reps_left=0, SEG=0x3F.
- Reset mid-operation aborts immediately; no done pulse is produced.
- Length clamp: eff_len = length if 1 <= length <= NBITS_PAT, otherwise NBITS_PAT. This covers length=0 and oversize values.
- IDLE, start=1 at an edge:
  - capture pattern, eff_len and reps_left=repeat_cnt;
  - state<=SEND, out_valid<=1, out_bit<=first bit, rem<=eff_len-1.
  - First bit appears 1 cycle after the accepting edge.
- SEND, rem!=0: shift, out_bit<=next bit, rem<=rem-1.
- SEND, rem==0 (last bit of the pass was on the output):
  - if reps_left!=0: state<=GAP, out_valid<=0, out_bit<=0, reps_left<=reps_left-1;
  - else: state<=DONE, out_valid<=0, out_bit<=0, done<=1.
- GAP: exactly one cycle. Reload the shift register from the captured pattern; state<=SEND, out_valid<=1, out_bit<=first bit, rem<=eff_len-1.
- DONE: done<=0, state<=IDLE; done is high for exactly this one cycle.
- Default bit order: LSB first, i.e. pattern[0], pattern[1], ..., pattern[eff_len-1].
- start while busy (SEND, GAP or DONE) is ignored, and the captured values are unchanged.
- abort=1 in SEND or GAP:
  - next edge: state<=IDLE, out_valid<=0, out_bit<=0, rem<=0, done stays 0.
  - abort has priority over end-of-pass handling.
  - abort in IDLE or DONE has no effect.
- start and abort both high in IDLE: start wins and abort is ignored.
- SEG encoding of rem[3:0]:
  - 0..7: 3F 06 5B 4F 66 6D 7D 07
  - 8..F: 7F 6F 77 7C 39 5E 79 71
- Timing totals for one start: busy-high cycles = (repeat_cnt+1)*eff_len + repeat_cnt + 1 (the DONE cycle) + 0 gap after the final pass.

Optional Feature:
- Macro: SEQ_TX_MSB_FIRST_EN.
- Defined: bits are sent MSB of the active field first, i.e. pattern[eff_len-1] down to pattern[0]. Shift direction and first-bit selection change accordingly.
- Undefined: LSB first, as above.
- Timing, rem, SEG, done, abort and repeat behaviour are identical in both builds.

Test Plan:
- Basic LSB-first send: assert reset during SEND, then release → all outputs at reset values immediately, SEG=0x3F. Then pattern=0xB5, length=8, repeat_cnt=0, start pulse → out_valid high on cycles 1..8 after the accepting edge, out_bit=1,0,1,0,1,1,0,1; SEG 0x07 on cycle 1 and 0x3F on cycle 8; done=1 on cycle 9 only; busy low from cycle 10.
- Repeats with gaps: pattern=0b101, length=3, repeat_cnt=2 → three passes of 1,0,1, each followed by one gap cycle (out_valid=0) for the first two passes; done on cycle 12; busy cycles = 9+2+1 = 12.
- Length clamp: length=0 and length=15, pattern=0xFF → 8 valid cycles of 1 in each case; a connected detector's LED[0] rises after the third bit.
- Abort and ignored start: abort asserted on the 4th valid bit of a length-8 send → out_valid=0 and busy=0 from the next edge, no done pulse. start pulsed mid-transfer → stream unchanged.
- Edge cases:
  - length=1, repeat_cnt=0, pattern=0x01 → single valid bit 1, done on the next cycle.
  - start held high continuously → a new transfer begins in the IDLE cycle after done.
- SEQ_TX_MSB_FIRST_EN defined: pattern=0xB5, length=4 → out_bit=0,1,0,1.
